// File: rtl/mine_place_ctrl_if.sv
// Control and result bundle between the minefield placer and its host logic.
interface mine_place_ctrl_if #(
   parameter int CELLS = 25,
   parameter int IDX_W = 5
);
   logic             in_start;
   logic [IDX_W-1:0] in_mult;
   logic [IDX_W-1:0] in_increment;
   logic [IDX_W-1:0] in_seed;
   logic [IDX_W-1:0] in_mines_num;
   logic [IDX_W-1:0] in_safe_cell;
   logic [CELLS-1:0] out_mines;
   logic [IDX_W-1:0] out_placed;
   logic             out_busy;
   logic             out_done;
   logic             out_error;

   modport master (
      output in_start, in_mult, in_increment, in_seed, in_mines_num, in_safe_cell,
      input  out_mines, out_placed, out_busy, out_done, out_error
   );

   modport slave (
      input  in_start, in_mult, in_increment, in_seed, in_mines_num, in_safe_cell,
      output out_mines, out_placed, out_busy, out_done, out_error
   );
endinterface

// File: rtl/mine_place_ctrl.sv
// Places mines on the board one LCG candidate per clock, skipping duplicates
// and the safe cell, bounded by a fixed step budget.
module mine_place_ctrl #(
   parameter int CELLS     = 25,
   parameter int IDX_W     = 5,
   parameter int MAX_STEPS = 64
) (
   input logic              in_clka,
   input logic              in_reset,
   mine_place_ctrl_if.slave bus
);
   localparam int STEP_W = $clog2(MAX_STEPS);
   localparam int PROD_W = 2 * IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_STEP = 3'd2,
      S_DONE = 3'd3,
      S_FAIL = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CELLS-1:0]  mines_q, mines_d;
   logic [IDX_W-1:0]  placed_q, placed_d;
   logic [IDX_W-1:0]  x_q, x_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [IDX_W-1:0]  a_q, a_d;
   logic [IDX_W-1:0]  c_q, c_d;
   logic [IDX_W-1:0]  seed_q, seed_d;
   logic [IDX_W-1:0]  num_q, num_d;
   logic [IDX_W-1:0]  safe_q, safe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [PROD_W-1:0] wide_s;
   logic [IDX_W-1:0]  x_next_s;
   logic [IDX_W-1:0]  placed_next_s;
   logic              hit_s;

   // Next-state and next-output computation for the placement sequencer.
   always_comb begin
      state_d  = state_q;
      mines_d  = mines_q;
      placed_d = placed_q;
      x_d      = x_q;
      step_d   = step_q;
      a_d      = a_q;
      c_d      = c_q;
      seed_d   = seed_q;
      num_d    = num_q;
      safe_d   = safe_q;
      busy_d   = busy_q;
      done_d   = done_q;
      error_d  = error_q;

      // Widened so a*X + c never wraps before the modulus is taken.
      wide_s        = PROD_W'(a_q) * PROD_W'(x_q) + PROD_W'(c_q);
      x_next_s      = IDX_W'(wide_s % PROD_W'(CELLS));
      hit_s         = (mines_q[x_q] == 1'b0) && (x_q != safe_q);
      placed_next_s = hit_s ? (placed_q + IDX_W'(1)) : placed_q;

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (bus.in_start) begin
               a_d    = bus.in_mult;
               c_d    = bus.in_increment;
               seed_d = bus.in_seed;
               num_d  = bus.in_mines_num;
               safe_d = bus.in_safe_cell;
               if (bus.in_mines_num > IDX_W'(CELLS - 1)) begin
                  state_d = S_FAIL;
                  busy_d  = 1'b0;
                  done_d  = 1'b0;
                  error_d = 1'b1;
               end else begin
                  state_d = S_INIT;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  error_d = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_INIT: begin
            mines_d  = '0;
            placed_d = '0;
            step_d   = '0;
            x_d      = IDX_W'(seed_q % IDX_W'(CELLS));
            if (num_q == IDX_W'(0)) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            if (hit_s) begin
               mines_d[x_q] = 1'b1;
            end else begin
               mines_d = mines_q;
            end
            placed_d = placed_next_s;
            x_d      = x_next_s;
            step_d   = step_q + STEP_W'(1);
            // Reaching the mine count wins over an exhausted budget on the same edge.
            if (placed_next_s == num_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
               state_d = S_FAIL;
               busy_d  = 1'b0;
               error_d = 1'b1;
            end else begin
               state_d = S_STEP;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
         end
      endcase
   end

   // State, latched operands and registered outputs.
   always_ff @(posedge in_clka) begin
      if (in_reset) begin
         state_q  <= S_IDLE;
         mines_q  <= '0;
         placed_q <= '0;
         x_q      <= '0;
         step_q   <= '0;
         a_q      <= '0;
         c_q      <= '0;
         seed_q   <= '0;
         num_q    <= '0;
         safe_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mines_q  <= mines_d;
         placed_q <= placed_d;
         x_q      <= x_d;
         step_q   <= step_d;
         a_q      <= a_d;
         c_q      <= c_d;
         seed_q   <= seed_d;
         num_q    <= num_d;
         safe_q   <= safe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.out_mines  = mines_q;
   assign bus.out_placed = placed_q;
   assign bus.out_busy   = busy_q;
   assign bus.out_done   = done_q;
   assign bus.out_error  = error_q;
endmodule

// File: tb/tb_mine_place_ctrl.sv
// Scoreboard bench: each run pushes the expected output changes (with the edge
// they must appear on); a monitor pops and compares whenever the outputs change.
module tb_mine_place_ctrl;
   typedef struct {
      int         cyc;
      logic       busy;
      logic       done;
      logic       error;
      logic [24:0] mines;
      logic [4:0]  placed;
   } snap_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   bit   mon_en;
   snap_t sb[$];
   snap_t traj[$];
   snap_t model_prev;
   logic [32:0] last_out;

   mine_place_ctrl_if #(.CELLS(25), .IDX_W(5)) bus_if ();

   mine_place_ctrl #(.CELLS(25), .IDX_W(5), .MAX_STEPS(64)) dut (
      .in_clka  (clk),
      .in_reset (rst),
      .bus      (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [32:0] pack_snap(input snap_t s);
      return {s.busy, s.done, s.error, s.mines, s.placed};
   endfunction

   function automatic logic [32:0] dut_out();
      return {bus_if.out_busy, bus_if.out_done, bus_if.out_error, bus_if.out_mines, bus_if.out_placed};
   endfunction

   // Monitor: every change of the output bundle is one observed response.
   always @(negedge clk) begin
      logic [32:0] cur;
      snap_t e;
      cur = dut_out();
      if (!mon_en) begin
         last_out = cur;
      end else if (cur != last_out) begin
         last_out = cur;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got %h at cyc %0d, want no change", cur, cyc);
         end else begin
            e = sb.pop_front();
            if (cur != pack_snap(e) || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL output_event: got busy=%0b done=%0b err=%0b mines=%h placed=%0d at cyc %0d, want busy=%0b done=%0b err=%0b mines=%h placed=%0d at cyc %0d",
                        cur[32], cur[31], cur[30], cur[29:5], cur[4:0], cyc,
                        e.busy, e.done, e.error, e.mines, e.placed, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Software model: expected outputs after each edge, offset from the start edge.
   task automatic build_traj(input int a, input int c, input int s, input int n, input int sf);
      snap_t t;
      int x;
      traj.delete();
      t = model_prev;
      t.cyc = 0;
      if (n > 24) begin
         t.busy = 1'b0; t.done = 1'b0; t.error = 1'b1;
         traj.push_back(t);
         return;
      end
      t.busy = 1'b1; t.done = 1'b0; t.error = 1'b0;
      traj.push_back(t);
      t.cyc = 1; t.mines = 25'd0; t.placed = 5'd0;
      if (n == 0) begin
         t.busy = 1'b0; t.done = 1'b1;
         traj.push_back(t);
         return;
      end
      traj.push_back(t);
      x = s % 25;
      for (int k = 0; k < 64; k++) begin
         t.cyc = 2 + k;
         if (t.mines[x] == 1'b0 && x != sf) begin
            t.mines[x] = 1'b1;
            t.placed = t.placed + 5'd1;
         end
         x = (a * x + c) % 25;
         if (int'(t.placed) == n) begin
            t.busy = 1'b0; t.done = 1'b1;
            traj.push_back(t);
            return;
         end
         if (k == 63) begin
            t.busy = 1'b0; t.error = 1'b1;
            traj.push_back(t);
            return;
         end
         traj.push_back(t);
      end
   endtask

   task automatic run(input int a, input int c, input int s, input int n, input int sf,
                      input int pulse_at, input int rst_at);
      int anchor;
      snap_t e;
      bit finished;
      build_traj(a, c, s, n, sf);
      @(negedge clk);
      anchor = cyc + 1;
      foreach (traj[i]) begin
         if (rst_at > 0 && traj[i].cyc >= rst_at) break;
         if (pack_snap(traj[i]) != pack_snap(model_prev)) begin
            e = traj[i];
            e.cyc = anchor + traj[i].cyc;
            sb.push_back(e);
         end
         model_prev = traj[i];
      end
      if (rst_at > 0) begin
         e.cyc = anchor + rst_at; e.busy = 1'b0; e.done = 1'b0; e.error = 1'b0;
         e.mines = 25'd0; e.placed = 5'd0;
         sb.push_back(e);
         model_prev = e;
      end
      bus_if.in_mult = 5'(a); bus_if.in_increment = 5'(c); bus_if.in_seed = 5'(s);
      bus_if.in_mines_num = 5'(n); bus_if.in_safe_cell = 5'(sf);
      bus_if.in_start = 1'b1;
      finished = 1'b0;
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && k > rst_at + 1) begin
            finished = 1'b1;
            bus_if.in_start = 1'b0;
            rst = 1'b0;
            break;
         end
         // Inputs change after the start edge; the latched copy must be used.
         bus_if.in_mult = 5'd2; bus_if.in_increment = 5'd3; bus_if.in_seed = 5'd9;
         bus_if.in_mines_num = 5'd1; bus_if.in_safe_cell = 5'd31;
         bus_if.in_start = (k == pulse_at);
         rst = (rst_at > 0 && k == rst_at);
      end
      bus_if.in_start = 1'b0;
      rst = 1'b0;
      if (!finished) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: got %0d pending responses, want 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      cyc = 0; n_cmp = 0; n_bad = 0; mon_en = 1'b0;
      rst = 1'b1;
      bus_if.in_start = 1'b0; bus_if.in_mult = 5'd0; bus_if.in_increment = 5'd0;
      bus_if.in_seed = 5'd0; bus_if.in_mines_num = 5'd0; bus_if.in_safe_cell = 5'd0;
      model_prev.cyc = 0; model_prev.busy = 1'b0; model_prev.done = 1'b0;
      model_prev.error = 1'b0; model_prev.mines = 25'd0; model_prev.placed = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_state", {7'd0, dut_out()}, 32'd0);
      mon_en = 1'b1;

      run(1, 1, 0, 3, 0, 0, 0);
      chk("t1_mines", {7'd0, bus_if.out_mines}, 32'h000000E);
      chk("t1_placed", {27'd0, bus_if.out_placed}, 32'd3);
      chk("t1_done", {31'd0, bus_if.out_done}, 32'd1);

      run(0, 5, 5, 2, 31, 0, 0);
      chk("t2_error", {31'd0, bus_if.out_error}, 32'd1);
      chk("t2_mines", {7'd0, bus_if.out_mines}, 32'h0000020);
      chk("t2_placed", {27'd0, bus_if.out_placed}, 32'd1);

      run(4, 2, 7, 0, 3, 0, 0);
      chk("t3_done", {31'd0, bus_if.out_done}, 32'd1);
      chk("t3_mines", {7'd0, bus_if.out_mines}, 32'd0);

      run(1, 1, 0, 25, 0, 0, 0);
      chk("t4_error", {31'd0, bus_if.out_error}, 32'd1);

      run(1, 1, 0, 24, 12, 0, 0);
      chk("t5_mines", {7'd0, bus_if.out_mines}, 32'h1FFEFFF);
      chk("t5_placed", {27'd0, bus_if.out_placed}, 32'd24);

      run(7, 3, 30, 5, 25, 0, 0);

      run(1, 1, 0, 3, 0, 3, 0);
      chk("pulse_mines", {7'd0, bus_if.out_mines}, 32'h000000E);

      run(1, 1, 0, 3, 0, 0, 3);
      chk("mid_reset_state", {7'd0, dut_out()}, 32'd0);
      run(1, 1, 0, 3, 0, 0, 0);
      chk("after_reset_done", {31'd0, bus_if.out_done}, 32'd1);

      run(3, 7, 24, 24, 12, 0, 0);
      chk("lcg_cycle_error", {31'd0, bus_if.out_error}, 32'd1);
      chk("lcg_cycle_mines", {7'd0, bus_if.out_mines}, 32'h1084010);
      chk("lcg_popcount", 32'($countones(bus_if.out_mines)), {27'd0, bus_if.out_placed});
      chk("lcg_safe_clear", {31'd0, bus_if.out_mines[12]}, 32'd0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mine_place_ctrl.md
Name: mine_place_ctrl

Overview:
- Sequencing controller that builds the 5x5 minefield one linear-congruential candidate per clock.
- Each candidate is X[n+1] = (a*X[n] + c) mod CELLS.
- Duplicates and the player's first-clicked (safe) cell are skipped. The controller stops when the requested mine count is placed.
- A step budget bounds runtime for degenerate seeds. The result is a 25-bit mine map for the board/reveal logic.

Parameters:
- CELLS, 25, number of board cells; also the LCG modulus.
- IDX_W, 5, width of cell indices and counts.
- MAX_STEPS, 64, maximum candidate evaluations before declaring failure.

Ports:
- in_clka  input  1  clock; all logic is on the rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  start request; honoured only in IDLE, DONE or FAIL.
- in_mult  input  IDX_W  multiplier a.
- in_increment  input  IDX_W  increment c.
- in_seed  input  IDX_W  initial value X0.
- in_mines_num  input  IDX_W  number of mines to place.
- in_safe_cell  input  IDX_W  cell that must not receive a mine; a value >= CELLS means no safe cell.
- out_mines  output  CELLS  mine map; bit i = 1 means cell i holds a mine.
- out_placed  output  IDX_W  mines placed so far.
- out_busy  output  1  high in INIT and STEP.
- out_done  output  1  high while in DONE.
- out_error  output  1  high while in FAIL.

Behaviour:
- Reset: state IDLE. out_mines=0, out_placed=0, out_busy=0, out_done=0, out_error=0. Internal X=0, step counter=0. Reset wins over every other event, including mid-STEP.
- States: IDLE, INIT, STEP, DONE, FAIL.
- IDLE/DONE/FAIL with in_start=1 at edge E0:
  - All inputs are latched into internal registers. Later input changes have no effect until the next start.
  - If latched mines_num > CELLS-1 (24), go to FAIL.
  - Otherwise go to INIT. out_busy=1, out_done=0, out_error=0.
- INIT (edge E1):
  - out_mines=0, out_placed=0, step=0.
  - X = seed mod CELLS.
  - If mines_num==0, go to DONE. Otherwise go to STEP.
- STEP (edges E2, E3, ...). Exactly one candidate, cand=X, is evaluated per edge:
  - If out_mines[cand]==0 and cand != safe_cell: set out_mines[cand], out_placed+1.
  - X <= (a*X + c) mod CELLS. The product and sum are computed at >= 2*IDX_W+1 bits with no truncation before the mod.
  - step <= step+1.
  - If this edge makes out_placed == mines_num, go to DONE on the same edge (out_busy=0, out_done=1).
  - Else if step == MAX_STEPS-1 (i.e. the MAX_STEPS-th evaluation), go to FAIL (out_busy=0, out_error=1).
  - Completion takes priority over the step budget on the same edge.
- DONE/FAIL:
  - Outputs hold until in_reset or a new in_start.
  - In FAIL, out_mines and out_placed show the partial result.
- in_start while out_busy=1 is ignored.
- Total latency: 2 + (number of candidate evaluations) edges from the edge that samples in_start to out_done.
- Invariants:
  - popcount(out_mines) == out_placed at all times.
  - The safe cell bit is never set.

Test Plan:
- a=1, c=1, seed=0, num=3, safe=0, start sampled at E0:
  - Candidates 0 (skipped, safe), 1, 2, 3 at E2..E5.
  - After E5: out_done=1, out_busy=0, out_mines=25'h000000E, out_placed=3.
- a=0, c=5, seed=5, num=2, safe=31:
  - Bit 5 is set at E2; every later candidate is the duplicate 5.
  - After E65: out_error=1, out_placed=1, out_mines=25'h0000020.
- num=0:
  - out_done=1 after E1, out_mines=0.
- num=25:
  - out_error=1 after E0; INIT is never entered.
- Mid-STEP control events:
  - Pulse in_start during STEP: ignored, and the sequence completes with the expected map.
  - Assert in_reset during STEP: the next cycle shows all outputs 0 and state IDLE.
  - A following in_start runs to completion normally.
- a=3, c=7, seed=24, num=24, safe=12:
  - If the run ends in DONE: out_mines == 25'h1FFFFFF with bit 12 cleared.
  - If the run ends in FAIL: popcount matches out_placed and bit 12 is clear.
  - In either case the bench compares every edge against a reference model.
